// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory load/store sequencer.
// Ports: none (package: access opcode enum, word-address mask, store-op helper).
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ld_byte_s      = 3'd0,
        ld_byte_u      = 3'd1,
        ld_half_word_s = 3'd2,
        ld_half_word_u = 3'd3,
        ld_word        = 3'd4,
        str_byte       = 3'd5,
        str_half_word  = 3'd6,
        str_word       = 3'd7
    } mem_operation_t;

    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    function automatic logic is_store(mem_operation_t op);
        return (op == str_byte) || (op == str_half_word) ||
               (op == str_word);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Load data aligner: shifts the addressed byte/half to bit 0 and extends.
// Ports: op (access type), off (addr[1:0]), word (memory word) -> data.
module mem_load_align
    import data_mem_ctrl_pkg::*;
(
    input  mem_operation_t op,
    input  logic [1:0]     off,
    input  logic [31:0]    word,
    output logic [31:0]    data
);

    logic [31:0] shifted;

    assign shifted = word >> {off, 3'b000};

    always_comb begin
        data = shifted;
        unique case (op)
            ld_byte_s:      data = {{24{shifted[7]}}, shifted[7:0]};
            ld_byte_u:      data = {24'h0, shifted[7:0]};
            ld_half_word_s: data = {{16{shifted[15]}}, shifted[15:0]};
            ld_half_word_u: data = {16'h0, shifted[15:0]};
            default:        data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a req/ack word memory.
// Ports: core side clk/rstN/req_i/op_i/addr_i/wdata_i -> stall/done/rdata/
// misalign/timeout; memory side mem_req/we/addr/be/wdata out, ack/rdata in.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           req_i,
    input  mem_operation_t op_i,
    input  logic [31:0]    addr_i,
    input  logic [31:0]    wdata_i,
    output logic           stall_o,
    output logic           done_o,
    output logic [31:0]    rdata_o,
    output logic           misalign_o,
    output logic           timeout_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic [31:0]    mem_addr_o,
    output logic [3:0]     mem_be_o,
    output logic [31:0]    mem_wdata_o,
    input  logic           mem_ack_i,
    input  logic [31:0]    mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } memCtrlState_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    memCtrlState_t  state_q;
    memCtrlState_t  state_d;
    logic [CW-1:0]  cnt_q;
    mem_operation_t op_q;
    logic [1:0]     off_q;
    logic [31:0]    addr_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;
    logic           we_q;
    logic [31:0]    rdata_q;
    logic           tmo_q;

    logic           is_byte;
    logic           is_half;
    logic           is_word;
    logic           misal;
    logic           tmo_hit;
    logic [3:0]     be_d;
    logic [31:0]    wdata_d;
    logic [31:0]    ld_data;

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        unique case (1'b1)
            (op_i == ld_byte_s) || (op_i == ld_byte_u) ||
            (op_i == str_byte):        is_byte = 1'b1;
            (op_i == ld_half_word_s) || (op_i == ld_half_word_u) ||
            (op_i == str_half_word):   is_half = 1'b1;
            default:                   is_word = 1'b1;
        endcase
    end

    assign misal = (is_half && addr_i[0]) ||
                   (is_word && (addr_i[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        unique case (1'b1)
            is_byte: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            is_half: begin
                be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata_i;
            end
        endcase
    end

    // Abort once the TIMEOUT-th consecutive WAIT cycle passes without ack.
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    mem_load_align u_align (
        .op   (op_q),
        .off  (off_q),
        .word (mem_rdata_i),
        .data (ld_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_i) state_d = misal ? ERR : WAIT;
            WAIT: begin
                if (mem_ack_i)    state_d = RESP;
                else if (tmo_hit) state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = (state_q == WAIT);
        done_o     = (state_q == RESP) || (state_q == ERR);
        misalign_o = (state_q == ERR) && !tmo_q;
        timeout_o  = (state_q == ERR) && tmo_q;
        stall_o    = ((state_q == IDLE) && req_i) || (state_q == WAIT);
    end

    assign rdata_o     = rdata_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= ld_byte_s;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (req_i && misal) begin
                        tmo_q <= 1'b0;
                    end else if (req_i) begin
                        op_q    <= op_i;
                        off_q   <= addr_i[1:0];
                        addr_q  <= addr_i & WORD_ADDR_MASK;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        we_q    <= is_store(op_i);
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        if (!is_store(op_q)) rdata_q <= ld_data;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (state_d == ERR) tmo_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus random accesses
// against a behavioural memory-access model.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rstN;
    logic           req_i;
    mem_operation_t op_i;
    logic [31:0]    addr_i;
    logic [31:0]    wdata_i;
    logic           stall_o;
    logic           done_o;
    logic [31:0]    rdata_o;
    logic           misalign_o;
    logic           timeout_o;
    logic           mem_req_o;
    logic           mem_we_o;
    logic [31:0]    mem_addr_o;
    logic [3:0]     mem_be_o;
    logic [31:0]    mem_wdata_o;
    logic           mem_ack_i;
    logic [31:0]    mem_rdata_i;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rdata = '0;

    data_mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req_i       (req_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input mem_operation_t op);
        case (op)
            ld_byte_s, ld_byte_u, str_byte:               return 1;
            ld_half_word_s, ld_half_word_u, str_half_word: return 2;
            default:                                       return 4;
        endcase
    endfunction

    function automatic bit m_store(input mem_operation_t op);
        return op == str_byte || op == str_half_word || op == str_word;
    endfunction

    function automatic bit m_misal(input mem_operation_t op,
                                   input logic [31:0] addr);
        return (addr % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input mem_operation_t op,
                                        input logic [31:0] addr);
        int lane = addr % 4;
        int mask = (1 << m_size(op)) - 1;
        return 4'((mask << lane) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input mem_operation_t op,
                                            input logic [31:0] w);
        logic [31:0] b = w % 256;
        logic [31:0] h = w % 65536;
        if (m_size(op) == 1) return b * 32'h0101_0101;
        if (m_size(op) == 2) return h * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input mem_operation_t op,
                                           input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] v = word / (32'd1 << (8 * (addr % 4)));
        case (op)
            ld_byte_s: begin
                v = v % 256;
                if (v >= 128) v = v - 256;
            end
            ld_byte_u: v = v % 256;
            ld_half_word_s: begin
                v = v % 65536;
                if (v >= 32768) v = v - 65536;
            end
            ld_half_word_u: v = v % 65536;
            default: v = word;
        endcase
        return v;
    endfunction

    // Starts at posedge+1 in IDLE, ends at posedge+1 back in IDLE.
    task automatic access(input mem_operation_t op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] word, input string tag);
        bit mis = m_misal(op, addr);
        bit st = m_store(op);
        int n = (delay < TMO) ? delay + 1 : TMO;
        req_i   = 1'b1;
        op_i    = op;
        addr_i  = addr;
        wdata_i = wdata;
        #1;
        chk(32'(stall_o), 32'd1, {tag, ".stall_acc"});
        @(posedge clk);
        #1;
        req_i  = 1'b0;
        addr_i = $urandom;
        if (mis) begin
            chk(32'(done_o), 32'd1, {tag, ".mis_done"});
            chk(32'(misalign_o), 32'd1, {tag, ".mis_flag"});
            chk(32'(timeout_o), 32'd0, {tag, ".mis_tmo"});
            chk(32'(mem_req_o), 32'd0, {tag, ".mis_req"});
            chk(32'(stall_o), 32'd0, {tag, ".mis_stall"});
        end else begin
            for (int k = 0; k < n; k++) begin
                chk(32'(mem_req_o), 32'd1, {tag, ".req"});
                chk(32'(stall_o), 32'd1, {tag, ".stall"});
                chk(32'(done_o), 32'd0, {tag, ".done_early"});
                chk(mem_addr_o, addr & 32'hFFFF_FFFC, {tag, ".addr"});
                chk(32'(mem_be_o), 32'(m_be(op, addr)), {tag, ".be"});
                chk(32'(mem_we_o), 32'(st), {tag, ".we"});
                if (st)
                    chk(mem_wdata_o, m_wdata(op, wdata), {tag, ".wdata"});
                if (k == delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = word;
                end
                @(posedge clk);
                #1;
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
            end
            chk(32'(done_o), 32'd1, {tag, ".done"});
            chk(32'(mem_req_o), 32'd0, {tag, ".req_off"});
            chk(32'(stall_o), 32'd0, {tag, ".stall_off"});
            chk(32'(misalign_o), 32'd0, {tag, ".mis_off"});
            if (delay < TMO) begin
                chk(32'(timeout_o), 32'd0, {tag, ".tmo_off"});
                if (!st) exp_rdata = m_load(op, addr, word);
                chk(rdata_o, exp_rdata, {tag, ".rdata"});
            end else begin
                chk(32'(timeout_o), 32'd1, {tag, ".tmo"});
            end
        end
        @(posedge clk);
        #1;
        chk(32'(done_o), 32'd0, {tag, ".done_pulse"});
        chk(rdata_o, exp_rdata, {tag, ".rdata_hold"});
    endtask

    initial begin
        rstN        = 1'b0;
        req_i       = 1'b0;
        op_i        = ld_byte_s;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(32'(done_o), 32'd0, "rst.done");
        chk(32'(stall_o), 32'd0, "rst.stall");
        chk(32'(mem_req_o), 32'd0, "rst.req");
        chk(rdata_o, 32'd0, "rst.rdata");
        chk(mem_addr_o, 32'd0, "rst.addr");
        chk(32'(mem_be_o), 32'd0, "rst.be");
        rstN = 1'b1;
        @(posedge clk);
        #1;

        access(str_byte, 32'h1003, 32'hAB, 0, 32'h0, "sb");
        access(ld_byte_s, 32'h1002, 32'h0, 0, 32'h12F45678, "lbs");
        access(ld_byte_u, 32'h1002, 32'h0, 1, 32'h12F45678, "lbu");
        access(ld_half_word_s, 32'h1002, 32'h0, 0, 32'h12F45678, "lhs");
        chk(rdata_o, 32'h0000_12F4, "lhs.lit");
        access(ld_half_word_u, 32'h1001, 32'h0, 0, 32'h0, "lhu_mis");
        access(ld_word, 32'h2000, 32'h0, 5, 32'hCAFE_F00D, "lw5");
        chk(rdata_o, 32'hCAFE_F00D, "lw5.lit");
        access(ld_word, 32'h3000, 32'h0, 100, 32'h0, "tmo");
        access(str_half_word, 32'h3002, 32'h1234_5678, 2, 32'h0, "sh_after");
        access(str_word, 32'h3006, 32'h1, 0, 32'h0, "sw_mis");

        req_i  = 1'b1;
        op_i   = ld_word;
        addr_i = 32'h2000;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        exp_rdata = '0;
        chk(32'(mem_req_o), 32'd0, "arst.req");
        chk(32'(stall_o), 32'd0, "arst.stall");
        chk(32'(done_o), 32'd0, "arst.done");
        chk(rdata_o, 32'd0, "arst.rdata");
        chk(mem_addr_o, 32'd0, "arst.addr");
        chk(32'(mem_we_o), 32'd0, "arst.we");
        @(posedge clk);
        #1;
        rstN        = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        chk(32'(done_o), 32'd0, "late_ack.done");
        chk(rdata_o, 32'd0, "late_ack.rdata");
        chk(32'(mem_req_o), 32'd0, "late_ack.req");

        for (int i = 0; i < 80; i++) begin
            mem_operation_t op = mem_operation_t'($urandom_range(0, 7));
            logic [31:0] a = $urandom & 32'h0000_FFFF;
            int d = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 4);
            access(op, a, $urandom, d, $urandom, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
